// File: rtl/axis_ctrlsrc_select_mc.sv
// Control-source selector: per-channel offset removal, channel select, linear/ln/avg/|x|+1 output.
// Latency: MON 1, ABS 2, control output 3 (ln mode 1); glitch-free switch via FLUSH/HOLD.
// Backpressure: none, streams are valid-only; output is frozen with tvalid low while switching.
module axis_ctrlsrc_select_mc #(
    parameter int N_CH             = 4,
    parameter int SAXIS_DATA_WIDTH = 32,
    parameter int MAXIS_DATA_WIDTH = 32,
    parameter int SHIFT            = 8,
    parameter int ADD_OFFSET       = 1,
    parameter int AVG_LOG2         = 4,
    parameter int SWITCH_HOLDOFF   = 16
) (
    input  logic                             a_clk,
    input  logic                             a_rst,
    input  logic [N_CH*SAXIS_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic [N_CH-1:0]                  S_AXIS_tvalid,
    input  logic [N_CH*SAXIS_DATA_WIDTH-1:0] signal_offset,
    input  logic [31:0]                      S_AXIS_LN_tdata,
    input  logic                             S_AXIS_LN_tvalid,
    input  logic [$clog2(N_CH)-1:0]          channel_select,
    input  logic [1:0]                       selection_mode,
    output logic [31:0]                      M_AXIS_ABS_tdata,
    output logic                             M_AXIS_ABS_tvalid,
    output logic [MAXIS_DATA_WIDTH-1:0]      M_AXIS_tdata,
    output logic                             M_AXIS_tvalid,
    output logic [N_CH*SAXIS_DATA_WIDTH-1:0] M_AXIS_MON_tdata,
    output logic [N_CH-1:0]                  M_AXIS_MON_tvalid,
    output logic                             switching
);
    localparam int W     = SAXIS_DATA_WIDTH;
    localparam int CW    = $clog2(N_CH);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = W + AVG_LOG2;
    localparam int CNT_W = $clog2(DEPTH + SWITCH_HOLDOFF) + 1;

    typedef enum logic [1:0] {S_FLUSH, S_HOLD, S_RUN} state_t;

    logic signed [W-1:0]     d_sh [N_CH];
    logic signed [W-1:0]     o_sh [N_CH];
    logic signed [W-1:0]     x    [N_CH];
    logic [N_CH-1:0]         mon_vld;
    logic [CW-1:0]           ch;
    logic [CW-1:0]           prev_ch;
    logic signed [W-1:0]     x_ch;
    logic [W-1:0]            mag;
    logic signed [W-1:0]     sel_x;
    logic signed [W-1:0]     hist [DEPTH];
    logic [AVG_LOG2-1:0]     wp;
    logic signed [SW-1:0]    sum;
    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    chg;
    logic                    flush_done;
    logic                    hold_done;
    logic                    run_nxt;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            d_sh[k] = $signed(S_AXIS_tdata[k*W +: W]) >>> SHIFT;
            o_sh[k] = '0;
            if (ADD_OFFSET != 0)
                o_sh[k] = $signed(signal_offset[k*W +: W]) >>> SHIFT;
        end
    end

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            for (int k = 0; k < N_CH; k++) x[k] <= '0;
            mon_vld <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) x[k] <= d_sh[k] + o_sh[k];
            mon_vld <= S_AXIS_tvalid;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_mon
        assign M_AXIS_MON_tdata[g*W +: W] = x[g];
    end
    assign M_AXIS_MON_tvalid = mon_vld;

    // Out-of-range selects clamp to the last channel
    always_comb begin
        ch = channel_select;
        if ({1'b0, channel_select} >= (CW+1)'(N_CH)) ch = CW'(N_CH - 1);
        x_ch = x[ch];
        mag  = x_ch[W-1] ? W'(-x_ch) : W'(x_ch);
    end

    assign chg        = (prev_ch != ch);
    assign flush_done = (state == S_FLUSH) && (cnt == CNT_W'(DEPTH - 1));
    assign hold_done  = (state == S_HOLD) && (cnt == CNT_W'(SWITCH_HOLDOFF - 1));
    assign run_nxt    = !chg && ((state == S_RUN) || hold_done);

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            sel_x             <= '0;
            M_AXIS_ABS_tdata  <= '0;
            M_AXIS_ABS_tvalid <= 1'b0;
        end else begin
            sel_x             <= x_ch;
            M_AXIS_ABS_tdata  <= 32'(mag + W'(1));
            M_AXIS_ABS_tvalid <= mon_vld[ch];
        end
    end

    // Switch sequencer and boxcar share the history buffer: FLUSH zeroes it slot by slot
    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            state     <= S_FLUSH;
            cnt       <= '0;
            wp        <= '0;
            prev_ch   <= '0;
            sum       <= '0;
            switching <= 1'b0;
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else begin
            prev_ch   <= ch;
            switching <= !run_nxt;
            if (chg) begin
                state <= S_FLUSH;
                cnt   <= '0;
                wp    <= '0;
                sum   <= '0;
            end else begin
                case (state)
                    S_FLUSH: begin
                        hist[wp] <= '0;
                        wp       <= wp + 1'b1;
                        sum      <= '0;
                        if (flush_done) begin
                            state <= S_HOLD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (hold_done) begin
                            state <= S_RUN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= S_RUN;
                endcase
            end
            if (run_nxt && mon_vld[ch]) begin
                sum      <= sum + SW'(x_ch) - SW'(hist[wp]);
                hist[wp] <= x_ch;
                wp       <= wp + 1'b1;
            end
        end
    end

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            M_AXIS_tdata  <= '0;
            M_AXIS_tvalid <= 1'b0;
        end else if (!run_nxt) begin
            M_AXIS_tvalid <= 1'b0;
        end else if (selection_mode == 2'd1) begin
            M_AXIS_tvalid <= S_AXIS_LN_tvalid;
            if (S_AXIS_LN_tvalid) M_AXIS_tdata <= MAXIS_DATA_WIDTH'(S_AXIS_LN_tdata);
        end else begin
            M_AXIS_tvalid <= M_AXIS_ABS_tvalid;
            if (M_AXIS_ABS_tvalid) begin
                case (selection_mode)
                    2'd0:    M_AXIS_tdata <= MAXIS_DATA_WIDTH'(sel_x);
                    2'd2:    M_AXIS_tdata <= MAXIS_DATA_WIDTH'(sum >>> AVG_LOG2);
                    default: M_AXIS_tdata <= MAXIS_DATA_WIDTH'(M_AXIS_ABS_tdata);
                endcase
            end
        end
    end
endmodule
